// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 codes and FSM state encoding shared by the dmem_ctrl slice
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;
endpackage

// File: rtl/dmem_align.sv
// dmem_align: load extract/extend + store merge; in we,funct3,addr_lo,rdata,wdata; out load_data,merged_word,misalign,illegal
module dmem_align
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word,
  output logic        misalign,
  output logic        illegal
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] bmask, hmask;
  assign b = 8'(rdata >> {addr_lo, 3'b000});
  assign h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  assign bmask = 32'h0000_00FF << {addr_lo, 3'b000};
  assign hmask = addr_lo[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
  assign illegal = we ? (funct3 > F3_W) : !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  assign misalign = (funct3[1:0] == 2'd1) ? addr_lo[0] : (funct3[1:0] == 2'd2) ? |addr_lo : 1'b0;
  assign load_data = (funct3[1:0] == 2'd0) ? {{24{b[7] & ~funct3[2]}}, b} :
                     (funct3[1:0] == 2'd1) ? {{16{h[15] & ~funct3[2]}}, h} : rdata;
  assign merged_word = (funct3[1:0] == 2'd0) ? (rdata & ~bmask) | ({4{wdata[7:0]}} & bmask) :
                       (funct3[1:0] == 2'd1) ? (rdata & ~hmask) | ({2{wdata[15:0]}} & hmask) : wdata;
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: load/store sequencer; req_* valid/ready in, resp_* one-cycle pulse out, ram_* word-wide RAM port
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  localparam int CW = $clog2(RD_LAT + 1);
  state_e            state_q, state_d;
  logic              we_q, we_d, err_q, err_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              idle, bad, misalign, illegal;
  logic [31:0]       load_data, merged_word;
  logic              unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W+2];
  assign idle = state_q == S_IDLE;
  assign bad = misalign | illegal;
  // In IDLE the aligner classifies the incoming request; afterwards it works on the captured one.
  // word_q holds store data until the read returns, then the merged word or the extracted load.
  dmem_align u_align (
    .we          (idle ? req_we : we_q),
    .funct3      (idle ? req_funct3 : f3_q),
    .addr_lo     (idle ? req_addr[1:0] : addr_q[1:0]),
    .rdata       (ram_rdata),
    .wdata       (word_q),
    .load_data   (load_data),
    .merged_word (merged_word),
    .misalign    (misalign),
    .illegal     (illegal)
  );
  assign req_ready  = idle;
  assign resp_valid = state_q == S_RESP;
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = (resp_valid && !we_q && !err_q) ? word_q : 32'h0;
  assign ram_we     = state_q == S_WRITE;
  assign ram_addr   = addr_q[ADDR_W+1:2];
  assign ram_wdata  = ram_we ? word_q : 32'h0;
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    word_d  = word_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        we_d    = req_we;
        f3_d    = req_funct3;
        addr_d  = req_addr[ADDR_W+1:0];
        word_d  = req_wdata;
        err_d   = bad;
        cnt_d   = '0;
        state_d = bad ? S_RESP : (req_we && req_funct3 == F3_W) ? S_WRITE : S_READ;
      end
      S_READ: if (cnt_q == CW'(RD_LAT)) begin
        word_d  = we_q ? merged_word : load_data;
        state_d = we_q ? S_WRITE : S_RESP;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      S_WRITE: state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scoreboard bench for dmem_ctrl with a one-cycle-latency behavioural RAM
module tb_dmem_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, ram_we;
  logic [31:0] resp_rdata, ram_wdata, ram_rdata;
  logic [7:0]  ram_addr;
  logic [31:0] mem [256];
  typedef struct {logic [31:0] rd; logic err; int lat;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0, cyc = 0, acc = 0, we_cnt = 0, stalls = 0, w0 = 0;
  always #5 clk = ~clk;
  dmem_ctrl #(.ADDR_W(8), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  always @(posedge clk) begin
    cyc++;
    if (req_valid && req_ready && !rst) acc = cyc;
  end
  always @(negedge clk) begin
    if (ram_we) we_cnt++;
    if (resp_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got rdata %0h err %0b want no response", resp_rdata, resp_err);
      end else begin
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rd);
        chk("resp_err", resp_err, e.err);
        chk("resp_latency", cyc - acc + 1, e.lat);
      end
    end
  end
  task automatic issue(bit we, logic [2:0] f3, logic [31:0] a, logic [31:0] d);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d; req_valid = 1'b1;
    for (int i = 0; i < 20 && !req_ready; i++) begin
      stalls++;
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL resp_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask
  task automatic req(bit we, logic [2:0] f3, logic [31:0] a, logic [31:0] d, logic [31:0] rd, logic err, int lat);
    sb.push_back('{rd, err, lat});
    issue(we, f3, a, d);
    req_valid = 1'b0;
    wait_done();
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h8001_7F80;
    mem[2] = 32'h1122_3344;
    repeat (2) @(negedge clk);
    chk("reset_ctl", {req_ready, resp_valid, resp_err, ram_we, ram_addr}, {4'b1000, 8'h00});
    chk("reset_data", {resp_rdata, ram_wdata}, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    req(0, 3'd0, 32'd0, 32'd0, 32'hFFFF_FF80, 0, 3);
    req(0, 3'd4, 32'd0, 32'd0, 32'h0000_0080, 0, 3);
    req(0, 3'd1, 32'd2, 32'd0, 32'hFFFF_8001, 0, 3);
    req(0, 3'd5, 32'd2, 32'd0, 32'h0000_8001, 0, 3);
    req(0, 3'd2, 32'd0, 32'd0, 32'h8001_7F80, 0, 3);
    w0 = we_cnt;
    req(1, 3'd0, 32'd1, 32'hAAAA_AA55, 32'h0, 0, 4);
    chk("sb_we_cycles", we_cnt - w0, 1);
    chk("sb_mem", mem[0], 32'h8001_5580);
    req(1, 3'd1, 32'd6, 32'h1234_BEEF, 32'h0, 0, 4);
    req(0, 3'd2, 32'd4, 32'd0, 32'hBEEF_0000, 0, 3);
    w0 = we_cnt;
    req(1, 3'd2, 32'd2, 32'hFFFF_FFFF, 32'h0, 1, 1);
    req(0, 3'd1, 32'd3, 32'd0, 32'h0, 1, 1);
    req(0, 3'd3, 32'd0, 32'd0, 32'h0, 1, 1);
    req(1, 3'd4, 32'd0, 32'hFFFF_FFFF, 32'h0, 1, 1);
    chk("err_no_write", we_cnt - w0, 0);
    chk("err_mem", mem[0], 32'h8001_5580);
    sb.push_back('{32'h0, 1'b0, 2});
    sb.push_back('{32'hCAFE_F00D, 1'b0, 3});
    issue(1, 3'd2, 32'h0000_0400, 32'hCAFE_F00D);
    stalls = 0;
    issue(0, 3'd2, 32'd0, 32'd0);
    req_valid = 1'b0;
    wait_done();
    chk("b2b_stall_cycles", stalls, 2);
    chk("wrap_mem", mem[0], 32'hCAFE_F00D);
    w0 = we_cnt;
    issue(1, 3'd0, 32'd8, 32'h0000_00FF);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_read_ready", {req_ready, resp_valid}, 2'b10);
    repeat (4) @(negedge clk);
    chk("rst_read_mem", mem[2], 32'h1122_3344);
    chk("rst_read_no_write", we_cnt - w0, 0);
    w0 = we_cnt;
    issue(1, 3'd2, 32'd12, 32'h5A5A_5A5A);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_write_ctl", {req_ready, resp_valid, resp_err, ram_we, ram_addr}, {4'b1000, 8'h00});
    chk("rst_write_data", {resp_rdata, ram_wdata}, 64'h0);
    chk("rst_write_mem", mem[3], 32'h5A5A_5A5A);
    chk("rst_write_we_cycles", we_cnt - w0, 1);
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test want end before 200000");
    $fatal(1, "watchdog");
  end
endmodule
